// File: rtl/scoreboard_engine.sv
// Multi-level timed-round scoreboard: BCD score/timer, bonus window, per-level pass check.
// Optional registered seven-segment decode is enabled with SCOREBOARD_SEG7_EN.
module scoreboard_engine #(
  parameter int SCORE_DIGITS = 3,
  parameter int TIMER_SECS   = 60,
  parameter int BONUS_SECS   = 15,
  parameter int NUM_LEVELS   = 2,
  parameter int PTS_NORMAL   = 2,
  parameter int PTS_BONUS    = 3,
  parameter int PASS_STEP    = 100,
  parameter int PASS_OFFSET  = 50,
  parameter int TICK_DIV     = 50_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      point,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [7:0]                timer_bcd,
  output logic [3:0]                level_bcd,
  output logic                      busy,
  output logic                      done,
  output logic                      win
`ifdef SCOREBOARD_SEG7_EN
  ,
  output logic [7*SCORE_DIGITS-1:0] seg7_score,
  output logic [13:0]               seg7_timer,
  output logic [6:0]                seg7_level
`endif
);
  localparam int SCORE_MAX = 10**SCORE_DIGITS - 1;
  localparam int BIN_W     = $clog2(10**SCORE_DIGITS);
  localparam int TICK_W    = $clog2(TICK_DIV);
  localparam logic [7:0] TIMER_INIT = {4'(TIMER_SECS / 10), 4'(TIMER_SECS % 10)};
  localparam logic [7:0] BONUS_LIM  = {4'(BONUS_SECS / 10), 4'(BONUS_SECS % 10)};

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_CHECK, S_NEXT, S_DONE} state_t;

  state_t                    r_state;
  logic [4*SCORE_DIGITS-1:0] r_score;
  logic [BIN_W-1:0]          r_score_bin;
  logic [7:0]                r_timer;
  logic [3:0]                r_level;
  logic [TICK_W-1:0]         r_tick;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_win;

  logic                      w_tick;
  logic [7:0]                w_timer_dec;
  logic [3:0]                w_pts;
  logic [SCORE_DIGITS:0]     w_carry;
  logic [4*SCORE_DIGITS-1:0] w_score_sum;
  logic [4*SCORE_DIGITS-1:0] w_score_add;
  logic [BIN_W:0]            w_bin_raw;
  logic [BIN_W-1:0]          w_bin_add;
  int                        w_threshold;
  logic                      w_pass;

  assign w_tick      = (r_tick == TICK_W'(TICK_DIV - 1));
  assign w_timer_dec = (r_timer[3:0] == 4'd0) ? {r_timer[7:4] - 4'd1, 4'd9}
                                              : {r_timer[7:4], r_timer[3:0] - 4'd1};
  // BCD ordering matches numeric ordering, so the window test needs no conversion
  assign w_pts       = (r_timer <= BONUS_LIM) ? 4'(PTS_BONUS) : 4'(PTS_NORMAL);

  assign w_carry[0] = 1'b0;
  for (genvar gi = 0; gi < SCORE_DIGITS; gi++) begin : g_add
    logic [4:0] w_addend;
    logic [4:0] w_raw;
    if (gi == 0) begin : g_lsd
      assign w_addend = {1'b0, w_pts};
    end else begin : g_upper
      assign w_addend = 5'd0;
    end
    assign w_raw                = {1'b0, r_score[4*gi+:4]} + w_addend + {4'd0, w_carry[gi]};
    assign w_carry[gi+1]        = (w_raw > 5'd9);
    assign w_score_sum[4*gi+:4] = w_carry[gi+1] ? 4'(w_raw - 5'd10) : w_raw[3:0];
  end

  assign w_score_add = w_carry[SCORE_DIGITS] ? {SCORE_DIGITS{4'h9}} : w_score_sum;
  assign w_bin_raw   = {1'b0, r_score_bin} + (BIN_W+1)'(w_pts);
  assign w_bin_add   = (w_bin_raw > (BIN_W+1)'(SCORE_MAX)) ? BIN_W'(SCORE_MAX) : w_bin_raw[BIN_W-1:0];
  assign w_threshold = int'(r_level) * PASS_STEP - PASS_OFFSET;
  assign w_pass      = (w_threshold <= 0) || (int'(r_score_bin) >= w_threshold);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_score     <= '0;
      r_score_bin <= '0;
      r_timer     <= TIMER_INIT;
      r_level     <= 4'd1;
      r_tick      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_win       <= 1'b0;
    end else if (start) begin
      // start restarts from any state; round variables are cleared on entry to INIT
      r_state     <= S_INIT;
      r_score     <= '0;
      r_score_bin <= '0;
      r_timer     <= TIMER_INIT;
      r_level     <= 4'd1;
      r_tick      <= '0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_win       <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: r_state <= S_RUN;
        S_RUN: begin
          r_tick <= w_tick ? '0 : r_tick + TICK_W'(1);
          if (point) begin
            r_score     <= w_score_add;
            r_score_bin <= w_bin_add;
          end
          if (w_tick) begin
            r_timer <= w_timer_dec;
            if (r_timer == 8'h01) r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_pass && (r_level < 4'(NUM_LEVELS))) begin
            r_state <= S_NEXT;
            r_level <= r_level + 4'd1;
            r_timer <= TIMER_INIT;
            r_tick  <= '0;
          end else begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_win   <= w_pass;
          end
        end
        S_NEXT:  r_state <= S_RUN;
        default: r_state <= r_state;
      endcase
    end
  end

  assign score_bcd = r_score;
  assign timer_bcd = r_timer;
  assign level_bcd = r_level;
  assign busy      = r_busy;
  assign done      = r_done;
  assign win       = r_win;

`ifdef SCOREBOARD_SEG7_EN
  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    case (d)
      4'd0: seg7_decode = 7'h3F;
      4'd1: seg7_decode = 7'h06;
      4'd2: seg7_decode = 7'h5B;
      4'd3: seg7_decode = 7'h4F;
      4'd4: seg7_decode = 7'h66;
      4'd5: seg7_decode = 7'h6D;
      4'd6: seg7_decode = 7'h7D;
      4'd7: seg7_decode = 7'h07;
      4'd8: seg7_decode = 7'h7F;
      4'd9: seg7_decode = 7'h6F;
      default: seg7_decode = 7'h00;
    endcase
  endfunction

  for (genvar gi = 0; gi < SCORE_DIGITS; gi++) begin : g_seg_score
    logic [6:0] r_seg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_seg <= 7'h3F;
      else        r_seg <= seg7_decode(r_score[4*gi+:4]);
    end
    assign seg7_score[7*gi+:7] = r_seg;
  end

  logic [13:0] r_seg_timer;
  logic [6:0]  r_seg_level;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_timer <= {7'h3F, 7'h3F};
      r_seg_level <= 7'h06;
    end else begin
      r_seg_timer <= {seg7_decode(r_timer[7:4]), seg7_decode(r_timer[3:0])};
      r_seg_level <= seg7_decode(r_level);
    end
  end
  assign seg7_timer = r_seg_timer;
  assign seg7_level = r_seg_level;
`endif
endmodule
